// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder_arbiter slice.
//   op_e      : operand selection code presented by each requester
//   rsp_t     : response payload (id, sum, carry) at the default widths
//   wrap_idx  : modular index helper used by the round-robin search
package adder_arb_pkg;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned MAX_ID_W  = 3;
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned CARRY_W   = 2;

    // Operand selection for the three-input adder
    typedef enum logic [1:0] {
        OP_AB   = 2'd0,
        OP_ACB  = 2'd1,
        OP_BCB  = 2'd2,
        OP_ABCB = 2'd3
    } op_e;

    // Response payload view at the default configuration
    typedef struct packed {
        logic [MAX_ID_W-1:0]  id;
        logic [DEF_WIDTH-1:0] sum;
        logic [CARRY_W-1:0]   carry;
    } rsp_t;

    // (base + off) mod n, used to walk requesters upward with wrap
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority requester index
//   grant_c : one-hot grant (zero when no request)
//   idx_c   : index of the granted requester
//   any_c   : at least one request present
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [ID_W-1:0]    idx_c,
    output logic               any_c
);

    // First requester at or after ptr, searching upward with wrap
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any_c && req[ID_W'(wrap_idx(32'(ptr), k, NUM_REQ))]) begin
                any_c   = 1'b1;
                idx_c   = ID_W'(wrap_idx(32'(ptr), k, NUM_REQ));
                grant_c[ID_W'(wrap_idx(32'(ptr), k, NUM_REQ))] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler sharing one registered three-operand
// adder among NUM_REQ requesters, with a single tagged, backpressured
// response port.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b/req_cb  : per-requester operands
//   req_op              : per-requester op_e
//   rsp_valid/rsp_ready : response handshake
//   rsp_id, rsp_sum     : owner tag and sum modulo 2^WIDTH
//   rsp_carry           : top two bits of the full sum, only when
//                         ADDER_ARB_CARRY_EN is defined
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_a,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_cb,
    input  logic [NUM_REQ-1:0][1:0]       req_op,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [WIDTH-1:0]              rsp_sum
`ifdef ADDER_ARB_CARRY_EN
    ,
    output logic [CARRY_W-1:0]            rsp_carry
`endif
);

`ifdef ADDER_ARB_CARRY_EN
    localparam int unsigned SUM_W = WIDTH + CARRY_W;
`else
    localparam int unsigned SUM_W = WIDTH;
`endif

    // Reject unsupported requester counts at elaboration
    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("adder_arbiter: NUM_REQ must be in 2..8");
    end

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] grant_c;
    logic [ID_W-1:0]    idx_c;
    logic               any_c;
    logic               can_issue_c;
    logic               xfer_c;
    logic [WIDTH-1:0]   op_a_c;
    logic [WIDTH-1:0]   op_b_c;
    logic [WIDTH-1:0]   op_cb_c;
    op_e                op_c;
    logic [SUM_W-1:0]   full_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    // A new result may be issued when the result register is empty or draining
    assign can_issue_c = !rsp_valid || rsp_ready;
    assign req_ready   = (can_issue_c && !rst) ? grant_c : '0;
    // Grant is only ever given to a valid requester, so any grant is a transfer
    assign xfer_c      = any_c && can_issue_c && !rst;

    // Operand mux from the granted requester
    assign op_a_c  = req_a[idx_c];
    assign op_b_c  = req_b[idx_c];
    assign op_cb_c = req_cb[idx_c];
    assign op_c    = op_e'(req_op[idx_c]);

    // Three-operand adder, sized to keep the carry bits when they are exported
    always_comb begin
        full_c = '0;
        unique case (op_c)
            OP_AB:   full_c = SUM_W'(op_a_c) + SUM_W'(op_b_c);
            OP_ACB:  full_c = SUM_W'(op_a_c) + SUM_W'(op_cb_c);
            OP_BCB:  full_c = SUM_W'(op_b_c) + SUM_W'(op_cb_c);
            OP_ABCB: full_c = SUM_W'(op_a_c) + SUM_W'(op_b_c) + SUM_W'(op_cb_c);
            default: full_c = '0;
        endcase
    end

    // Round-robin pointer: moves just past the granted requester on transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer_c) begin
            ptr_q <= ID_W'(wrap_idx(32'(idx_c), 1, NUM_REQ));
        end
    end

    // Result register: reload on transfer (back-to-back), clear valid on drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else if (xfer_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= idx_c;
            rsp_sum   <= full_c[WIDTH-1:0];
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ADDER_ARB_CARRY_EN
    // Carry bits follow the same load/hold rule as the sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_carry <= '0;
        end else if (xfer_c) begin
            rsp_carry <= full_c[SUM_W-1:WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: self-checking bench for adder_arbiter (NUM_REQ=4, WIDTH=8)
// against a behavioural model of the round-robin and arithmetic rules.
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][W-1:0]   req_a;
    logic [N-1:0][W-1:0]   req_b;
    logic [N-1:0][W-1:0]   req_cb;
    logic [N-1:0][1:0]     req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [W-1:0]          rsp_sum;
`ifdef ADDER_ARB_CARRY_EN
    logic [1:0]            rsp_carry;
`endif

    int   checks = 0;
    int   errors = 0;
    int   m_ptr;
    bit   m_valid;
    rsp_t m_rsp;
    int   last_grant;

    always #5 clk = ~clk;

    adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cb    (req_cb),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum)
`ifdef ADDER_ARB_CARRY_EN
        ,
        .rsp_carry (rsp_carry)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_sum(input int a, input int b, input int cb, input int op);
        case (op)
            0:       return a + b;
            1:       return a + cb;
            2:       return b + cb;
            default: return a + b + cb;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_rsp   = '0;
    endtask

    task automatic check_rsp(input string tag);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'(m_valid));
        check_eq({tag, "_id"},    32'(rsp_id),    32'(m_rsp.id));
        check_eq({tag, "_sum"},   32'(rsp_sum),   32'(m_rsp.sum));
`ifdef ADDER_ARB_CARRY_EN
        check_eq({tag, "_carry"}, 32'(rsp_carry), 32'(m_rsp.carry));
`endif
    endtask

    // One clock: inputs already driven at the negedge; check grant, step model, check result
    task automatic run_cycle(input string tag);
        int           g;
        int           full;
        logic [N-1:0] exp_ready;
        #1;
        g = -1;
        if (!m_valid || rsp_ready) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        if (g >= 0) begin
            full        = model_sum(int'(req_a[g]), int'(req_b[g]), int'(req_cb[g]), int'(req_op[g]));
            m_valid     = 1'b1;
            m_rsp.id    = 3'(g);
            m_rsp.sum   = 8'(full % 256);
            m_rsp.carry = 2'(full / 256);
            m_ptr       = (g + 1) % N;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        last_grant = g;
        #1;
        check_rsp(tag);
        @(negedge clk);
    endtask

    task automatic rand_req(input int i);
        req_a[i]  = W'($urandom);
        req_b[i]  = W'($urandom);
        req_cb[i] = W'($urandom);
        req_op[i] = 2'($urandom);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        rsp_ready  = 1'b1;
        last_grant = -1;
        for (int i = 0; i < N; i++) rand_req(i);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_eq("reset_req_ready", 32'(req_ready), 32'h0);
        check_rsp("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 2
        req_valid = 4'b0100;
        req_a[2] = 8'h10; req_b[2] = 8'h20; req_op[2] = 2'(OP_AB);
        run_cycle("single");
        check_eq("single_sum_const", 32'(rsp_sum), 32'h30);

        // Wrap: pointer at 3, only requester 0 valid
        req_valid = 4'b0001;
        run_cycle("wrap");
        req_valid = 4'b1111;
        run_cycle("wrap_next");

        // Overflow with all three operands at max
        req_valid = 4'b0100;
        req_a[2] = 8'hFF; req_b[2] = 8'hFF; req_cb[2] = 8'hFF; req_op[2] = 2'(OP_ABCB);
        run_cycle("ovf");
        check_eq("ovf_sum_const", 32'(rsp_sum), 32'hFD);
`ifdef ADDER_ARB_CARRY_EN
        check_eq("ovf_carry_const", 32'(rsp_carry), 32'h2);
`endif

        // Fairness: all valid, drain every cycle
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (last_grant >= 0) rand_req(last_grant);
            run_cycle("fair");
        end

        // Backpressure: hold the result for three cycles, then release
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) run_cycle("bp_stall");
        rsp_ready = 1'b1;
        run_cycle("bp_release");

        // Reset while a result is pending and stalled
        rsp_ready = 1'b0;
        run_cycle("pre_rst");
        rst = 1'b1;
        #1;
        model_reset();
        check_eq("rst_async_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_req_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        run_cycle("post_rst");

        // Randomized traffic; ungranted valid requesters keep their operands
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_grant == i) rand_req(i);
            end
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            run_cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
